axi_cfg_arbiter: RTL and testbench

Shares the single AXI4-Lite configuration port of the AXI node's region/connectivity register block between N_REQ simple request/response masters, such as boot loader, debug unit and core-side config agent. Each requester issues one register read or write. The block picks one winner round-robin, runs exactly one AXI-Lite transaction at a time toward the register block, and returns read data and error status to the winning requester. It sits between the config agents and the register block's s_axi_* slave port.

---
 rtl/axi_cfg_pkg.sv | 25 ++
 rtl/axi_cfg_rr_arb.sv | 28 ++
 rtl/axi_cfg_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_axi_cfg_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cfg_pkg.sv
// Shared types and constants for the AXI-Lite configuration-port arbiter.
//   state_t        : transaction FSM states
//   AXI_RESP_OKAY  : BRESP/RRESP value treated as success
//   N_REQ_MAX      : largest supported requester count
//   idx_w()        : width of a requester index for a given requester count
package axi_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         N_REQ_MAX     = 8;

    // At least one bit, so the index is a legal vector even for tiny N.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi_cfg_rr_arb.sv
// Combinational round-robin picker.
//   req    : pending request vector
//   rr_ptr : index of the highest-priority requester this round
//   gnt    : one-hot winner (all zero when nothing is pending)
// The pointer itself is owned and advanced by the caller.
module axi_cfg_rr_arb
    import axi_cfg_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [idx_w(N_REQ)-1:0]     rr_ptr,
    output logic [N_REQ-1:0]            gnt
);

    logic [N_REQ-1:0] hi_mask;
    logic [N_REQ-1:0] hi_req;

    // Requests at or above the pointer have priority; if none, wrap to the
    // lowest set bit overall. x & -x isolates the lowest set bit.
    always_comb begin
        hi_mask = ~((N_REQ'(1) << rr_ptr) - N_REQ'(1));
        hi_req  = req & hi_mask;
        if (|hi_req) gnt = hi_req & (~hi_req + N_REQ'(1));
        else         gnt = req & (~req + N_REQ'(1));
    end

endmodule

// File: rtl/axi_cfg_arbiter.sv
// Shares one AXI4-Lite master port between N_REQ request/response agents.
// One transaction is in flight at a time; winners are chosen round-robin.
// Ports:
//   s_axi_aclk / s_axi_areset : clock, async active-high reset
//   req_*_i                   : per-requester request + payload (slice r = requester r)
//   req_gnt_o                 : one-hot pulse in the cycle the request is captured
//   rsp_valid_o               : one-hot pulse to the owner when the transaction completes
//   rsp_rdata_o / rsp_err_o   : last read data / error status of the completed transaction
//   m_axi_*                   : AXI4-Lite master toward the register block
module axi_cfg_arbiter
    import axi_cfg_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int N_REQ            = 2
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,
    input  logic [N_REQ-1:0]              req_valid_i,
    input  logic [N_REQ-1:0]              req_we_i,
    input  logic [N_REQ*C_AXI_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_REQ*C_AXI_DATA_WIDTH-1:0] req_wdata_i,
    input  logic [N_REQ*4-1:0]            req_be_i,
    output logic [N_REQ-1:0]              req_gnt_o,
    output logic [N_REQ-1:0]              rsp_valid_o,
    output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int IW = idx_w(N_REQ);

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_ptr, ptr_nxt;
    logic [N_REQ-1:0] arb_gnt;
    logic [N_REQ-1:0] owner_oh;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [3:0]       be_q;
    logic [DW-1:0]    rdata_q;
    logic             err_q;
    logic             aw_done, w_done;
    logic             aw_fire, w_fire;

    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic [3:0]       sel_be;

    axi_cfg_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req    (req_valid_i),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt)
    );

    // One-hot grant -> winner payload and the pointer value that follows it.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        ptr_nxt   = rr_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_we    = req_we_i[i];
                sel_addr  = req_addr_i[i*AW +: AW];
                sel_wdata = req_wdata_i[i*DW +: DW];
                sel_be    = req_be_i[i*4 +: 4];
                ptr_nxt   = (i == N_REQ-1) ? '0 : IW'(i+1);
            end
        end
    end

    assign aw_fire = m_axi_awvalid && m_axi_awready;
    assign w_fire  = m_axi_wvalid  && m_axi_wready;

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // All AXI valids/readies decode from registered state only, so none of
    // them depends combinationally on a slave ready.
    always_comb begin
        state_d       = state_q;
        req_gnt_o     = '0;
        rsp_valid_o   = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            IDLE: begin
                // A grant seen while reset is held would never be captured.
                if (!s_axi_areset) req_gnt_o = arb_gnt;
                if (|req_valid_i) state_d = sel_we ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_d = DONE;
            end
            RD_REQ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_d = DONE;
            end
            DONE: begin
                rsp_valid_o = owner_oh;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload is loaded only in IDLE, which keeps AXI payload stable while
    // any valid is pending and makes requester inputs don't-care afterwards.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            rr_ptr   <= '0;
            owner_oh <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (|req_valid_i) begin
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        be_q     <= sel_be;
                        owner_oh <= arb_gnt;
                        rr_ptr   <= ptr_nxt;
                    end
                end
                WR_REQ: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (m_axi_bvalid) err_q <= (m_axi_bresp != AXI_RESP_OKAY);
                end
                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        rdata_q <= m_axi_rdata;
                        err_q   <= (m_axi_rresp != AXI_RESP_OKAY);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata_o  = rdata_q;
    assign rsp_err_o    = err_q;
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = be_q;

endmodule

// File: tb/tb_axi_cfg_arbiter.sv
module tb_axi_cfg_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_we = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR*4-1:0]   req_be = '0;
    logic [NR-1:0]     req_gnt, rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     awaddr, araddr;
    logic [DW-1:0]     wdata, rdata;
    logic [3:0]        wstrb;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [1:0]        bresp, rresp;

    int errors = 0;
    int checks = 0;

    // slave controls
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rdata_v = '0;
    int          aw_wait, w_wait, ar_wait;
    logic        got_aw, got_w;

    wire [4:0] axv = {awvalid, wvalid, bready, arvalid, rready};

    always #5 clk = ~clk;

    axi_cfg_arbiter #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .N_REQ(NR)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_be_i(req_be),
        .req_gnt_o(req_gnt), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // Simple AXI-Lite slave with programmable ready latencies; shares reset.
    assign awready = awvalid && (aw_wait >= aw_lat);
    assign wready  = wvalid  && (w_wait  >= w_lat);
    assign arready = arvalid && (ar_wait >= ar_lat);
    assign bresp   = bresp_v;
    assign rresp   = rresp_v;
    assign rdata   = rdata_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            got_aw <= 1'b0; got_w <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid  && !wready)  ? w_wait + 1  : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready))) begin
                bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
            end else begin
                if (awvalid && awready) got_aw <= 1'b1;
                if (wvalid && wready)   got_w  <= 1'b1;
            end
            if (arvalid && arready)    rvalid <= 1'b1;
            else if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // sample/drive point: 1 time unit after the falling edge
    task automatic nx;
        @(negedge clk); #1;
    endtask

    task automatic set_req(input int r, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        req_valid[r] = 1'b1;
        req_we[r] = we;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
        req_be[r*4 +: 4] = be;
    endtask

    task automatic apply_reset;
        nx; rst = 1'b1; nx; rst = 1'b0;
    endtask

    task automatic test_reset;
        nx;
        checks++; if (axv !== 5'b0) begin errors++; $display("FAIL rst_axv got=%b exp=00000", axv); end
        checks++; if ({req_gnt, rsp_valid} !== 4'b0) begin errors++; $display("FAIL rst_gnt_rsp got=%b exp=0000", {req_gnt, rsp_valid}); end
        checks++; if ({rsp_rdata, rsp_err} !== 33'b0) begin errors++; $display("FAIL rst_rsp got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
        checks++; if ({awaddr, araddr, wdata, wstrb} !== 100'b0) begin errors++; $display("FAIL rst_payload got=%h %h %h %h exp=0", awaddr, araddr, wdata, wstrb); end
        rst = 1'b0;
    endtask

    task automatic test_single_write;
        nx; set_req(0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF); #1;
        checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL sw_gnt got=%b exp=01", req_gnt); end
        checks++; if (axv !== 5'b0) begin errors++; $display("FAIL sw_T_axv got=%b exp=00000", axv); end
        nx; req_valid = '0;
        checks++; if (axv !== 5'b11000) begin errors++; $display("FAIL sw_T1_axv got=%b exp=11000", axv); end
        checks++; if ({awaddr, wstrb, wdata} !== {32'h10, 4'hF, 32'hCAFEF00D}) begin errors++; $display("FAIL sw_T1_payload got=%h %h %h exp=10 f cafef00d", awaddr, wstrb, wdata); end
        checks++; if ({awready, wready, req_gnt} !== 4'b1100) begin errors++; $display("FAIL sw_T1_rdy got=%b exp=1100", {awready, wready, req_gnt}); end
        nx;
        checks++; if ({axv, bvalid} !== 6'b001001) begin errors++; $display("FAIL sw_T2_b got=%b exp=001001", {axv, bvalid}); end
        nx;
        checks++; if ({rsp_valid, rsp_err, axv} !== 8'b01_0_00000) begin errors++; $display("FAIL sw_T3_rsp got=%b exp=01000000", {rsp_valid, rsp_err, axv}); end
        nx;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL sw_T4_rsp got=%b exp=00", rsp_valid); end
    endtask

    task automatic test_contention;
        logic [1:0]  g_val[4];
        int          g_cyc[4];
        logic [31:0] ar_seen[4];
        int          ng = 0, na = 0;
        apply_reset;
        nx; set_req(0, 1'b0, 32'h00, 32'h0, 4'h0); set_req(1, 1'b0, 32'h04, 32'h0, 4'h0); #1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) nx;
            if (req_gnt != 2'b00) begin
                if (ng < 4) begin g_val[ng] = req_gnt; g_cyc[ng] = c; end
                ng++;
            end
            if (arvalid && arready) begin
                if (na < 4) ar_seen[na] = araddr;
                na++;
            end
            if (c == 13) req_valid = '0;
        end
        nx;
        checks++; if (ng !== 4 || na !== 4) begin errors++; $display("FAIL ct_count got=%0d/%0d exp=4/4", ng, na); end
        for (int i = 0; i < 4 && i < ng && i < na; i++) begin
            checks++;
            if (g_val[i] !== ((i % 2) ? 2'b10 : 2'b01) || g_cyc[i] !== 4*i || ar_seen[i] !== ((i % 2) ? 32'h4 : 32'h0)) begin
                errors++;
                $display("FAIL ct_grant%0d got=%b@%0d addr=%h exp=%b@%0d addr=%h", i, g_val[i], g_cyc[i], ar_seen[i],
                         (i % 2) ? 2'b10 : 2'b01, 4*i, (i % 2) ? 32'h4 : 32'h0);
            end
        end
    endtask

    task automatic test_indep_aw_w;
        logic [4:0] exp_axv[7];
        int nb = 0;
        exp_axv[1] = 5'b11000; exp_axv[2] = 5'b01000; exp_axv[3] = 5'b01000;
        exp_axv[4] = 5'b01000; exp_axv[5] = 5'b00100; exp_axv[6] = 5'b00000;
        w_lat = 3;
        nx; set_req(0, 1'b1, 32'h30, 32'h11223344, 4'h3); #1;
        checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL aw_gnt got=%b exp=01", req_gnt); end
        for (int c = 1; c <= 8; c++) begin
            nx;
            if (c == 1) req_valid = '0;
            if (bvalid && bready) nb++;
            if (c <= 6) begin
                checks++; if (axv !== exp_axv[c]) begin errors++; $display("FAIL aw_T%0d_axv got=%b exp=%b", c, axv, exp_axv[c]); end
            end
            if (c == 1) begin
                checks++; if ({awready, wready, wstrb} !== 6'b10_0011) begin errors++; $display("FAIL aw_T1_rdy got=%b exp=100011", {awready, wready, wstrb}); end
            end
            if (c == 4) begin
                checks++; if (wready !== 1'b1) begin errors++; $display("FAIL aw_T4_wready got=%b exp=1", wready); end
            end
            if (c == 6) begin
                checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL aw_T6_rsp got=%b exp=01", rsp_valid); end
            end
        end
        checks++; if (nb !== 1) begin errors++; $display("FAIL aw_b_count got=%0d exp=1", nb); end
        w_lat = 0;
    endtask

    task automatic test_read_error;
        int np = 0;
        rresp_v = 2'b10; rdata_v = 32'h12345678;
        nx; set_req(1, 1'b0, 32'h20, 32'h0, 4'h0); #1;
        checks++; if (req_gnt !== 2'b10) begin errors++; $display("FAIL re_gnt got=%b exp=10", req_gnt); end
        for (int c = 1; c <= 7; c++) begin
            nx;
            if (c == 1) req_valid = '0;
            if (rsp_valid != 2'b00) np++;
            if (c == 1) begin
                checks++; if ({axv, araddr} !== {5'b00010, 32'h20}) begin errors++; $display("FAIL re_T1 got=%b %h exp=00010 20", axv, araddr); end
            end
            if (c == 2) begin
                checks++; if ({axv, rvalid} !== 6'b000011) begin errors++; $display("FAIL re_T2 got=%b exp=000011", {axv, rvalid}); end
            end
            if (c == 3) begin
                checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b1, 32'h12345678}) begin errors++; $display("FAIL re_T3_rsp got=%b %b %h exp=10 1 12345678", rsp_valid, rsp_err, rsp_rdata); end
            end
        end
        checks++; if (np !== 1) begin errors++; $display("FAIL re_pulses got=%0d exp=1", np); end
        checks++; if (rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL re_hold got=%h exp=12345678", rsp_rdata); end
        rresp_v = 2'b00;
    endtask

    task automatic test_backpressure;
        ar_lat = 5; rdata_v = 32'hA5A50001;
        nx; set_req(0, 1'b0, 32'h44, 32'h0, 4'h0); set_req(1, 1'b1, 32'h50, 32'h99, 4'hF); #1;
        checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL bp_gnt got=%b exp=01", req_gnt); end
        for (int c = 1; c <= 5; c++) begin
            nx;
            checks++; if ({axv, arready, req_gnt, araddr} !== {5'b00010, 1'b0, 2'b00, 32'h44}) begin errors++; $display("FAIL bp_T%0d got=%b %b %b %h exp=00010 0 00 44", c, axv, arready, req_gnt, araddr); end
        end
        nx;
        checks++; if ({axv, arready, req_gnt} !== 8'b00010_1_00) begin errors++; $display("FAIL bp_T6 got=%b exp=00010100", {axv, arready, req_gnt}); end
        req_valid = '0;
        nx;
        checks++; if (axv !== 5'b00001) begin errors++; $display("FAIL bp_T7 got=%b exp=00001", axv); end
        nx;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'hA5A50001}) begin errors++; $display("FAIL bp_T8_rsp got=%b %b %h exp=01 0 a5a50001", rsp_valid, rsp_err, rsp_rdata); end
        nx;
        checks++; if ({rsp_valid, req_gnt} !== 4'b0) begin errors++; $display("FAIL bp_T9 got=%b exp=0000", {rsp_valid, req_gnt}); end
        ar_lat = 0;
    endtask

    task automatic test_reset_mid_write;
        nx; set_req(0, 1'b1, 32'h60, 32'hDEADBEEF, 4'hF); #1;
        checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL rm_gnt got=%b exp=01", req_gnt); end
        nx; req_valid = '0;
        nx;
        checks++; if (axv !== 5'b00100) begin errors++; $display("FAIL rm_wr_resp got=%b exp=00100", axv); end
        rst = 1'b1; #1;
        checks++; if ({axv, rsp_valid, req_gnt, rsp_err} !== 10'b0) begin errors++; $display("FAIL rm_ctl got=%b exp=0", {axv, rsp_valid, req_gnt, rsp_err}); end
        checks++; if ({rsp_rdata, awaddr, wdata, wstrb} !== 100'b0) begin errors++; $display("FAIL rm_data got=%h %h %h %h exp=0", rsp_rdata, awaddr, wdata, wstrb); end
        nx; nx; rst = 1'b0;
        nx;
        checks++; if ({axv, rsp_valid} !== 7'b0) begin errors++; $display("FAIL rm_after got=%b exp=0", {axv, rsp_valid}); end
        rdata_v = 32'h0BADF00D;
        set_req(0, 1'b0, 32'h08, 32'h0, 4'h0); set_req(1, 1'b0, 32'h0C, 32'h0, 4'h0); #1;
        checks++; if (req_gnt !== 2'b01) begin errors++; $display("FAIL rm_ptr_gnt got=%b exp=01", req_gnt); end
        nx; req_valid = '0;
        checks++; if ({axv, araddr} !== {5'b00010, 32'h08}) begin errors++; $display("FAIL rm_ar got=%b %h exp=00010 08", axv, araddr); end
        nx; nx;
        checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'h0BADF00D}) begin errors++; $display("FAIL rm_rsp got=%b %b %h exp=01 0 0badf00d", rsp_valid, rsp_err, rsp_rdata); end
        nx;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rm_rsp_end got=%b exp=00", rsp_valid); end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_contention;
        test_indep_aw_w;
        test_read_error;
        test_backpressure;
        test_reset_mid_write;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
